alu_frame_interface: RTL and testbench
======================================

// Module: alu_frame_interface
// PURPOSE
//  UART-to-ALU frame engine: pops an opcode byte plus two NB_DATA-bit operands (LSB byte first) from the RX FIFO,
//  drives the ALU, waits ALU_LATENCY cycles, then pushes the NB_DATA-bit result (LSB byte first) into the TX FIFO.
//  Adds multi-byte operands, a parametrised ALU latency, and an inter-byte timeout with error reporting.
//  Sits between uart_rx FIFO / uart_tx FIFO and the ALU in the UART top level.
// PARAMETERS
//  NB_BYTE       8     UART byte width
//  NB_DATA       16    ALU operand/result width; must be a multiple of NB_BYTE (NBYTES = NB_DATA/NB_BYTE >= 1)
//  NB_OP         6     opcode width; taken from i_rd_data[NB_OP-1:0]
//  ALU_LATENCY   1     cycles between operands/op stable and i_result valid (>= 1)
//  TIMEOUT       50000 max idle cycles between bytes inside a frame (>= 2)
//  NB_ERRCNT     8     width of error counter
// PORTS
//  i_clk         in   1         clock
//  i_reset       in   1         synchronous, active-high reset
//  i_rd_data     in   NB_BYTE   RX FIFO head (first-word-fall-through, valid while ~i_empty)
//  i_empty       in   1         RX FIFO empty
//  o_rd          out  1         RX pop strobe (combinational)
//  i_full        in   1         TX FIFO full
//  o_wr          out  1         TX push strobe (combinational)
//  o_wr_data     out  NB_BYTE   TX byte
//  o_op          out  NB_OP     ALU opcode (registered)
//  o_data_a      out  NB_DATA   ALU operand A (registered)
//  o_data_b      out  NB_DATA   ALU operand B (registered)
//  i_result      in   NB_DATA   ALU result
//  o_busy        out  1         high whenever state != IDLE
//  o_frame_err   out  1         one-cycle pulse on timeout abort
//  o_err_count   out  NB_ERRCNT saturating count of aborted frames
// BEHAVIOUR
//  Reset: state=IDLE; o_op, o_data_a, o_data_b, o_err_count, byte/latency/timeout counters, result shifter = 0;
//   o_rd=o_wr=o_busy=o_frame_err=0. Reset mid-frame discards everything, no TX bytes emitted afterwards.
//  States: IDLE -> GET_A -> GET_B -> EXEC -> SEND -> IDLE.
//  o_rd = ~i_empty & (state in {IDLE,GET_A,GET_B}); byte captured on the same edge; max 1 byte/cycle,
//   back-to-back pops allowed.
//  IDLE: on pop, o_op <= i_rd_data[NB_OP-1:0], byte_cnt <= 0, to GET_A. IDLE never times out.
//  GET_A/GET_B: each pop shifts byte into operand at position byte_cnt (LSB first); on pop with
//   byte_cnt==NBYTES-1 -> next state, byte_cnt <= 0. Operand register updates only when the whole operand is
//   assembled (no partial values on o_data_a/b).
//  Timeout: tmo_cnt clears on every pop and on entering GET_A; increments in GET_A/GET_B when i_empty;
//   reaching TIMEOUT-1 -> IDLE, o_frame_err pulses 1 cycle, o_err_count +1 (saturates at all-ones),
//   o_op/o_data_a/o_data_b keep last completed values. Pop on the same cycle as terminal count wins (no abort).
//  EXEC: lat_cnt counts ALU_LATENCY cycles after o_data_b update; then res_sh <= i_result, send_cnt <= 0, to SEND.
//  SEND: o_wr = ~i_full; o_wr_data = res_sh[NB_BYTE-1:0]; on push shift res_sh right by NB_BYTE;
//   after NBYTES pushes -> IDLE. i_full stalls indefinitely without data loss; RX not popped during EXEC/SEND.
//  Latency: last B byte pop -> first o_wr possible ALU_LATENCY+1 cycles later with i_full=0.
// STRUCTURE
//  Shared header uart_alu_defs.vh: state encodings, NB_BYTE default, opcode constants shared with ALU.
//  One sub-module: frame_timeout_counter (clear, enable, terminal-count pulse, parameter TIMEOUT).
//  Byte assembly/serialisation and FSM stay in this module.
// TESTING
//  NB_DATA=16, LAT=1: RX 20,34,12,01,01, ALU ADD -> o_op=0x20, A=0x1234, B=0x0101, TX 35,13, then o_busy=0.
//  Same frame with i_full held high 20 cycles in SEND -> no o_wr while full, then exactly 35,13 in order.
//  Bytes 20,34 then silence TIMEOUT cycles -> o_frame_err one pulse, o_err_count=1, no TX, next frame correct.
//  Byte arrives exactly on the terminal-count cycle -> no abort, frame completes normally.
//  i_reset asserted in GET_B -> all outputs 0, no TX; following full frame processed normally.
//  NB_DATA=8, LAT=3: RX 22,0F,F0 -> single TX byte = i_result latched 3 cycles after B; 300 frames back-to-back,
//   no loss.

Source files
------------

// File: rtl/alu_frame_interface_pkg.sv
// Shared definitions for the UART-to-ALU frame engine: FSM state encoding, byte width
// default and the opcode values the ALU decodes.
package alu_frame_interface_pkg;

  localparam int NB_BYTE_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_EXEC,
    ST_SEND
  } state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/frame_timeout_counter.sv
// Idle-cycle counter for the inter-byte timeout; tc is high on the enabled cycle that
// reaches TIMEOUT-1, so a clear arriving on that cycle always wins.
module frame_timeout_counter #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt;

  assign tc = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_frame_interface.sv
// Frame engine between the UART FIFOs and the ALU: opcode plus two LSB-first operands in,
// LSB-first result out, with an inter-byte timeout that aborts and counts broken frames.
module alu_frame_interface
  import alu_frame_interface_pkg::*;
#(
  parameter int NB_BYTE     = NB_BYTE_DEF,
  parameter int NB_DATA     = 16,
  parameter int NB_OP       = 6,
  parameter int ALU_LATENCY = 1,
  parameter int TIMEOUT     = 50000,
  parameter int NB_ERRCNT   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_BYTE-1:0]   i_rd_data,
  input  logic                 i_empty,
  output logic                 o_rd,
  input  logic                 i_full,
  output logic                 o_wr,
  output logic [NB_BYTE-1:0]   o_wr_data,
  output logic [NB_OP-1:0]     o_op,
  output logic [NB_DATA-1:0]   o_data_a,
  output logic [NB_DATA-1:0]   o_data_b,
  input  logic [NB_DATA-1:0]   i_result,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic [NB_ERRCNT-1:0] o_err_count
);

  localparam int NBYTES = NB_DATA / NB_BYTE;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int LAT_W  = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(ALU_LATENCY - 1);

  state_t             state;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   send_cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [NB_DATA-1:0] opnd_asm;
  logic [NB_DATA-1:0] assembled;
  logic [NB_DATA-1:0] res_sh;
  logic               in_rx;
  logic               tmo_en;
  logic               tmo_tc;

  function automatic logic [NB_ERRCNT-1:0] sat_inc(input logic [NB_ERRCNT-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_rx     = (state == ST_IDLE) || (state == ST_GET_A) || (state == ST_GET_B);
  assign o_rd      = in_rx && !i_empty;
  assign o_wr      = (state == ST_SEND) && !i_full;
  assign o_wr_data = res_sh[NB_BYTE-1:0];
  assign o_busy    = (state != ST_IDLE);
  assign tmo_en    = ((state == ST_GET_A) || (state == ST_GET_B)) && i_empty;

  // Operands are built in a scratch register so o_data_a/b only ever show complete values.
  always_comb begin
    assembled = opnd_asm;
    assembled[int'(byte_cnt) * NB_BYTE +: NB_BYTE] = i_rd_data;
  end

  frame_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (i_clk),
    .reset  (i_reset),
    .clear  (o_rd),
    .enable (tmo_en),
    .tc     (tmo_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      send_cnt    <= '0;
      lat_cnt     <= '0;
      opnd_asm    <= '0;
      res_sh      <= '0;
      o_op        <= '0;
      o_data_a    <= '0;
      o_data_b    <= '0;
      o_frame_err <= 1'b0;
      o_err_count <= '0;
    end else begin
      o_frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (o_rd) begin
            o_op     <= i_rd_data[NB_OP-1:0];
            byte_cnt <= '0;
            state    <= ST_GET_A;
          end
        end
        ST_GET_A, ST_GET_B: begin
          if (o_rd) begin
            opnd_asm <= assembled;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              if (state == ST_GET_A) begin
                o_data_a <= assembled;
                state    <= ST_GET_B;
              end else begin
                o_data_b <= assembled;
                lat_cnt  <= '0;
                state    <= ST_EXEC;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (tmo_tc) begin
            byte_cnt    <= '0;
            o_frame_err <= 1'b1;
            o_err_count <= sat_inc(o_err_count);
            state       <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (lat_cnt == LAST_LAT) begin
            res_sh   <= i_result;
            send_cnt <= '0;
            state    <= ST_SEND;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          // A full TX FIFO simply holds the shifter; nothing is dropped.
          if (!i_full) begin
            res_sh <= res_sh >> NB_BYTE;
            if (send_cnt == LAST_BYTE) begin
              state <= ST_IDLE;
            end else begin
              send_cnt <= send_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_frame_interface.sv
// Directed bench for alu_frame_interface: a 16-bit/latency-1 instance and an 8-bit/latency-3
// instance, each fed by a FIFO model and an ALU model with the matching pipeline depth.
module tb_alu_frame_interface;
  import alu_frame_interface_pkg::*;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rxd   [2];
  logic        empty [2];
  logic        rd    [2];
  logic        full  [2];
  logic        wr    [2];
  logic [7:0]  wdata [2];
  logic        busy  [2];
  logic        ferr  [2];
  logic [7:0]  ecnt  [2];
  logic [5:0]  opo   [2];
  logic [15:0] a16, b16, res16;
  logic [7:0]  a8, b8, res8;
  logic [15:0] p1, p2;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int pop_cyc [2];
  int first_wr [2];
  int errp [2];
  logic [7:0] txq0[$];
  logic [7:0] txq1[$];
  logic [7:0] exp1[$];

  always #5 clk = ~clk;

  alu_frame_interface #(
    .NB_BYTE(8), .NB_DATA(16), .NB_OP(6), .ALU_LATENCY(1), .TIMEOUT(TMO), .NB_ERRCNT(8)
  ) dut16 (
    .i_clk(clk), .i_reset(reset), .i_rd_data(rxd[0]), .i_empty(empty[0]), .o_rd(rd[0]),
    .i_full(full[0]), .o_wr(wr[0]), .o_wr_data(wdata[0]), .o_op(opo[0]), .o_data_a(a16),
    .o_data_b(b16), .i_result(res16), .o_busy(busy[0]), .o_frame_err(ferr[0]),
    .o_err_count(ecnt[0])
  );

  alu_frame_interface #(
    .NB_BYTE(8), .NB_DATA(8), .NB_OP(6), .ALU_LATENCY(3), .TIMEOUT(TMO), .NB_ERRCNT(8)
  ) dut8 (
    .i_clk(clk), .i_reset(reset), .i_rd_data(rxd[1]), .i_empty(empty[1]), .o_rd(rd[1]),
    .i_full(full[1]), .o_wr(wr[1]), .o_wr_data(wdata[1]), .o_op(opo[1]), .o_data_a(a8),
    .o_data_b(b8), .i_result(res8), .o_busy(busy[1]), .o_frame_err(ferr[1]),
    .o_err_count(ecnt[1])
  );

  function automatic logic [15:0] alu(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      default: return 16'h0000;
    endcase
  endfunction

  // Latency 1: result combinational from the registered operands; latency 3: two register stages.
  assign res16 = alu(opo[0], a16, b16);
  always @(posedge clk) begin
    p1 <= alu(opo[1], {8'h00, a8}, {8'h00, b8});
    p2 <= p1;
  end
  assign res8 = p2[7:0];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #1;
    if (wr[0]) begin
      txq0.push_back(wdata[0]);
      if (first_wr[0] < 0) first_wr[0] = cyc;
    end
    if (wr[1]) begin
      txq1.push_back(wdata[1]);
      if (first_wr[1] < 0) first_wr[1] = cyc;
    end
    if (ferr[0]) errp[0]++;
    if (ferr[1]) errp[1]++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the pop.
  task automatic put_byte(input int d, input logic [7:0] b);
    int n;
    n = 0;
    rxd[d] = b;
    empty[d] = 1'b0;
    #1;
    while (!rd[d] && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rd[d]) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_pop dut%0d: byte 0x%0h not popped after %0d cycles", d, b, n);
    end
    pop_cyc[d] = cyc;
    @(negedge clk);
    empty[d] = 1'b1;
  endtask

  task automatic wait_idle(input int d, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (busy[d] && n < 300);
    check(name, 32'(busy[d]), 0);
  endtask

  task automatic frame16(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    put_byte(0, op);
    put_byte(0, a[7:0]);
    put_byte(0, a[15:8]);
    put_byte(0, b[7:0]);
    put_byte(0, b[15:8]);
  endtask

  task automatic check_tx16(input string name, input logic [15:0] res);
    check({name, "_txcount"}, 32'(txq0.size()), 2);
    if (txq0.size() == 2) begin
      check({name, "_tx0"}, 32'(txq0[0]), 32'(res[7:0]));
      check({name, "_tx1"}, 32'(txq0[1]), 32'(res[15:8]));
    end
    txq0.delete();
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  exp_op;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs [7];
  logic [5:0] ops [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op, a, b;
    logic [15:0] r;
    int bad;

    vecs[0] = '{8'h20, 16'h1234, 16'h0101, 6'h20, 16'h1335};
    vecs[1] = '{8'h22, 16'h1000, 16'h0001, 6'h22, 16'h0FFF};
    vecs[2] = '{8'h24, 16'hF0FF, 16'h3C0F, 6'h24, 16'h300F};
    vecs[3] = '{8'h25, 16'hA000, 16'h0005, 6'h25, 16'hA005};
    vecs[4] = '{8'h26, 16'hFFFF, 16'h1234, 6'h26, 16'hEDCB};
    vecs[5] = '{8'hE0, 16'hFFFF, 16'h0001, 6'h20, 16'h0000};
    vecs[6] = '{8'h27, 16'hFF00, 16'h0F00, 6'h27, 16'h00FF};
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR};

    for (int d = 0; d < 2; d++) begin
      rxd[d] = 8'h00; empty[d] = 1'b1; full[d] = 1'b0;
      first_wr[d] = -1; pop_cyc[d] = 0; errp[d] = 0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_busy%0d", d), 32'(busy[d]), 0);
      check($sformatf("rst_ferr%0d", d), 32'(ferr[d]), 0);
      check($sformatf("rst_ecnt%0d", d), 32'(ecnt[d]), 0);
      check($sformatf("rst_wr%0d", d), 32'(wr[d]), 0);
      check($sformatf("rst_op%0d", d), 32'(opo[d]), 0);
    end
    check("rst_a16", 32'(a16), 0);
    check("rst_b16", 32'(b16), 0);
    @(negedge clk);

    // Table of complete 16-bit frames.
    for (int i = 0; i < 7; i++) begin
      first_wr[0] = -1;
      put_byte(0, vecs[i].op);
      put_byte(0, vecs[i].a[7:0]);
      #1;
      if (i > 0) check($sformatf("v%0d_a_partial", i), 32'(a16), 32'(vecs[i-1].a));
      put_byte(0, vecs[i].a[15:8]);
      put_byte(0, vecs[i].b[7:0]);
      #1;
      if (i > 0) check($sformatf("v%0d_b_partial", i), 32'(b16), 32'(vecs[i-1].b));
      put_byte(0, vecs[i].b[15:8]);
      wait_idle(0, $sformatf("v%0d_idle", i));
      check($sformatf("v%0d_op", i), 32'(opo[0]), 32'(vecs[i].exp_op));
      check($sformatf("v%0d_a", i), 32'(a16), 32'(vecs[i].a));
      check($sformatf("v%0d_b", i), 32'(b16), 32'(vecs[i].b));
      check($sformatf("v%0d_latency", i), 32'(first_wr[0] - pop_cyc[0]), 2);
      check_tx16($sformatf("v%0d", i), vecs[i].exp_res);
    end

    // TX FIFO full for a long stretch in SEND.
    full[0] = 1'b1;
    frame16(8'h20, 16'h1234, 16'h0101);
    repeat (22) @(negedge clk);
    #1;
    check("stall_no_wr", 32'(txq0.size()), 0);
    check("stall_busy", 32'(busy[0]), 1);
    @(negedge clk);
    full[0] = 1'b0;
    wait_idle(0, "stall_idle");
    check_tx16("stall", 16'h1335);

    // Silence of exactly TMO cycles inside a frame aborts it.
    put_byte(0, 8'h20);
    put_byte(0, 8'h34);
    repeat (TMO) @(negedge clk);
    #1;
    check("tmo_pulse_now", 32'(ferr[0]), 1);
    repeat (5) @(negedge clk);
    #1;
    check("tmo_pulse_count", 32'(errp[0]), 1);
    check("tmo_ecnt", 32'(ecnt[0]), 1);
    check("tmo_busy", 32'(busy[0]), 0);
    check("tmo_keep_a", 32'(a16), 'h1234);
    check("tmo_keep_b", 32'(b16), 'h0101);
    check("tmo_no_tx", 32'(txq0.size()), 0);
    frame16(8'h22, 16'h0050, 16'h0010);
    wait_idle(0, "tmo_next_idle");
    check_tx16("tmo_next", 16'h0040);

    // Byte arriving on the terminal-count cycle is taken, no abort.
    put_byte(0, 8'h20);
    put_byte(0, 8'h34);
    repeat (TMO - 1) @(negedge clk);
    put_byte(0, 8'h12);
    put_byte(0, 8'h01);
    put_byte(0, 8'h01);
    wait_idle(0, "tc_idle");
    check("tc_pulses", 32'(errp[0]), 1);
    check("tc_ecnt", 32'(ecnt[0]), 1);
    check("tc_a", 32'(a16), 'h1234);
    check_tx16("tc", 16'h1335);

    // Reset in the middle of operand B.
    put_byte(0, 8'h25);
    put_byte(0, 8'h0F);
    put_byte(0, 8'hF0);
    put_byte(0, 8'h01);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_op", 32'(opo[0]), 0);
    check("midrst_a", 32'(a16), 0);
    check("midrst_b", 32'(b16), 0);
    check("midrst_ecnt", 32'(ecnt[0]), 0);
    check("midrst_busy", 32'(busy[0]), 0);
    check("midrst_ferr", 32'(ferr[0]), 0);
    repeat (10) @(negedge clk);
    #1;
    check("midrst_no_tx", 32'(txq0.size()), 0);
    @(negedge clk);
    frame16(8'h20, 16'h1234, 16'h0101);
    wait_idle(0, "midrst_next_idle");
    check_tx16("midrst_next", 16'h1335);

    // 8-bit, latency-3 instance: single frame, then a long back-to-back run.
    first_wr[1] = -1;
    put_byte(1, 8'h22);
    put_byte(1, 8'h0F);
    put_byte(1, 8'hF0);
    wait_idle(1, "n8_idle");
    check("n8_op", 32'(opo[1]), 'h22);
    check("n8_a", 32'(a8), 'h0F);
    check("n8_b", 32'(b8), 'hF0);
    check("n8_latency", 32'(first_wr[1] - pop_cyc[1]), 4);
    check("n8_txcount", 32'(txq1.size()), 1);
    if (txq1.size() == 1) check("n8_tx", 32'(txq1[0]), 'h1F);
    txq1.delete();

    for (int i = 0; i < 300; i++) begin
      op = {2'b00, ops[$urandom_range(0, 5)]};
      a  = 8'($urandom);
      b  = 8'($urandom);
      r  = alu(op[5:0], {8'h00, a}, {8'h00, b});
      exp1.push_back(r[7:0]);
      put_byte(1, op);
      put_byte(1, a);
      put_byte(1, b);
    end
    wait_idle(1, "burst_idle");
    check("burst_count", 32'(txq1.size()), 300);
    bad = 0;
    for (int i = 0; i < 300 && i < txq1.size(); i++) begin
      if (txq1[i] !== exp1[i]) begin
        if (bad < 5) $display("FAIL burst_byte%0d: got 0x%0h, expected 0x%0h", i, txq1[i], exp1[i]);
        bad++;
      end
    end
    check("burst_bytes_bad", 32'(bad), 0);
    check("burst_ecnt", 32'(ecnt[1]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
